// File: rtl/wb_stage_pipe.sv
// wb_stage_pipe: Y86-64 write-back stage register with RF write ports, forwarding, halt latch and retire counter
module wb_stage_pipe #(
  parameter int DATA_W = 64,
  parameter int RADDR_W = 4,
  parameter logic [RADDR_W-1:0] RNONE = '1,
  parameter int CNT_W = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               m_valid_i,
  input  logic [3:0]         m_icode_i,
  input  logic [1:0]         m_stat_i,
  input  logic [RADDR_W-1:0] m_dste_i,
  input  logic [RADDR_W-1:0] m_dstm_i,
  input  logic [DATA_W-1:0]  m_vale_i,
  input  logic [DATA_W-1:0]  m_valm_i,
  input  logic               w_stall_i,
  input  logic               w_bubble_i,
  output logic               rf_we_e_o,
  output logic [RADDR_W-1:0] rf_addr_e_o,
  output logic [DATA_W-1:0]  rf_data_e_o,
  output logic               rf_we_m_o,
  output logic [RADDR_W-1:0] rf_addr_m_o,
  output logic [DATA_W-1:0]  rf_data_m_o,
  output logic [RADDR_W-1:0] fwd_dste_o,
  output logic [RADDR_W-1:0] fwd_dstm_o,
  output logic [1:0]         stat_o,
  output logic               halted_o,
  output logic [CNT_W-1:0]   retired_o
);
  logic               valid_q, valid_d;
  logic [3:0]         icode_q, icode_d;
  logic [1:0]         stat_q, stat_d;
  logic [RADDR_W-1:0] dste_q, dste_d, dstm_q, dstm_d;
  logic [DATA_W-1:0]  vale_q, vale_d, valm_q, valm_d;
  logic               halted_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               act, fault, bub, load, unused_icode;
  assign act   = valid_q & (stat_q == 2'b00) & ~halted_q;
  assign fault = valid_q & (stat_q != 2'b00);
  // a faulting instruction freezes W immediately so stat_o keeps showing it once halted
  assign bub   = ~halted_q & ~fault & w_bubble_i;
  assign load  = ~halted_q & ~fault & ~w_bubble_i & ~w_stall_i;
  assign unused_icode = ^icode_q;
  // W register next state: bubble beats stall, halt/fault freezes everything
  always_comb begin
    valid_d = bub ? 1'b0  : load ? m_valid_i : valid_q;
    icode_d = bub ? 4'h1  : load ? m_icode_i : icode_q;
    stat_d  = bub ? 2'b00 : load ? m_stat_i  : stat_q;
    dste_d  = bub ? RNONE : load ? m_dste_i  : dste_q;
    dstm_d  = bub ? RNONE : load ? m_dstm_i  : dstm_q;
    vale_d  = bub ? '0    : load ? m_vale_i  : vale_q;
    valm_d  = bub ? '0    : load ? m_valm_i  : valm_q;
    cnt_d   = (act & (w_bubble_i | ~w_stall_i) & (cnt_q != '1)) ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;
  end
  // state registers with synchronous reset to the bubble
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      icode_q  <= 4'h1;
      stat_q   <= 2'b00;
      dste_q   <= RNONE;
      dstm_q   <= RNONE;
      vale_q   <= '0;
      valm_q   <= '0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      icode_q  <= icode_d;
      stat_q   <= stat_d;
      dste_q   <= dste_d;
      dstm_q   <= dstm_d;
      vale_q   <= vale_d;
      valm_q   <= valm_d;
      halted_q <= halted_q | fault;
      cnt_q    <= cnt_d;
    end
  end
  assign rf_we_m_o   = act & (dstm_q != RNONE);
  assign rf_we_e_o   = act & (dste_q != RNONE) & (dste_q != dstm_q);
  assign rf_addr_e_o = dste_q;
  assign rf_addr_m_o = dstm_q;
  assign rf_data_e_o = vale_q;
  assign rf_data_m_o = valm_q;
  assign fwd_dste_o  = rf_we_e_o ? dste_q : RNONE;
  assign fwd_dstm_o  = rf_we_m_o ? dstm_q : RNONE;
  assign stat_o      = valid_q ? stat_q : 2'b00;
  assign halted_o    = halted_q;
  assign retired_o   = cnt_q;
endmodule

// File: doc/wb_stage_pipe.md
Name: wb_stage_pipe

Overview:
- Registered write-back (W) stage for the pipelined Y86-64 core.
- Captures the memory-stage result bundle in a pipeline register under stall/bubble control.
- Drives two register-file write ports (E and M), a forwarding bundle and the architectural status.
- Holds a sticky halt latch and a saturating retired-instruction counter; width, register-address width and counter width are parametrised.

Parameters:
- DATA_W, 64, width of valE/valM and of register-file write data.
- RADDR_W, 4, register index width.
- RNONE, 4'hF, register index meaning "no destination"; width RADDR_W.
- CNT_W, 32, retired-instruction counter width.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- m_valid_i  in  1  M-stage bundle holds a real instruction.
- m_icode_i  in  4  instruction code.
- m_stat_i  in  2  status from upstream stages: 00 AOK, 01 HLT, 10 ADR, 11 INS.
- m_dste_i  in  RADDR_W  destination register for valE.
- m_dstm_i  in  RADDR_W  destination register for valM.
- m_vale_i  in  DATA_W  ALU result.
- m_valm_i  in  DATA_W  memory read data.
- w_stall_i  in  1  hold the W register.
- w_bubble_i  in  1  load a bubble into the W register.
- rf_we_e_o  out  1  write enable, port E.
- rf_addr_e_o  out  RADDR_W  write address, port E.
- rf_data_e_o  out  DATA_W  write data, port E.
- rf_we_m_o  out  1  write enable, port M.
- rf_addr_m_o  out  RADDR_W  write address, port M.
- rf_data_m_o  out  DATA_W  write data, port M.
- fwd_dste_o  out  RADDR_W  W-stage dstE for forwarding (RNONE when not writing).
- fwd_dstm_o  out  RADDR_W  W-stage dstM for forwarding (RNONE when not writing).
- stat_o  out  2  architectural status of the instruction in W.
- halted_o  out  1  sticky: a non-AOK instruction has retired.
- retired_o  out  CNT_W  count of AOK instructions retired.

Behaviour:
- Reset (rst_i=1 at an edge), values from the next cycle:
  - W register = bubble: valid=0, icode=1 (NOP), stat=00, dstE=dstM=RNONE, valE=valM=0.
  - halted_o=0, retired_o=0.
  - All rf_we_*=0, fwd_* = RNONE, stat_o=00.
  - Reset overrides every other input. Reset mid-stall or while halted clears everything.
- W register update priority: rst_i > halted_o > w_bubble_i > w_stall_i > load.
  - halted_o=1: W register and counter freeze; the stage ignores m_*.
  - bubble: load the reset bubble.
  - stall: hold the current contents.
  - load: capture all m_* fields.
  - w_bubble_i and w_stall_i both high: bubble wins.
- Latency: 1 cycle from M-stage bundle to register-file write. All rf_*, fwd_* and stat_o outputs are combinational from the W register only.
- Write-enable conditions:
  - Let act = w_valid & (w_stat==00) & ~halted_o.
  - rf_we_e_o = act & (w_dstE != RNONE).
  - rf_we_m_o = act & (w_dstM != RNONE).
- Same-register collision: when both ports target the same index, port M wins and rf_we_e_o is forced 0. This gives popq %rsp semantics.
- rf_addr_* and rf_data_* always reflect the W register, regardless of enable.
- Forwarding: fwd_dste_o = rf_we_e_o ? w_dstE : RNONE. fwd_dstm_o follows the same rule with port M.
- stat_o:
  - Equals w_stat when w_valid=1.
  - Equals 00 for a bubble.
  - Continues to show the faulting status while halted.
- Halt latch: set at the edge where the W register holds valid & w_stat!=00 and halted_o=0. It stays set until reset. The faulting instruction itself writes nothing.
- Counter:
  - Increments by 1 at each edge where act=1 and the W register is not stalled. A stalled instruction is counted once, on the cycle it leaves W.
  - It also counts when the next cycle loads a bubble.
  - Saturates at 2^CNT_W-1; no wrap.
- All arithmetic is unsigned, widths exactly as listed. No X may propagate to outputs after reset.

Test Plan:
- Reset then load irmovq (icode 3, dstE=2, valE=0x1234, dstM=F) -> next cycle rf_we_e_o=1, addr 2, data 0x1234; rf_we_m_o=0; retired_o becomes 1 one edge later.
- popq %rsp (dstE=4, dstM=4, valE=0x100, valM=0xBEEF) -> rf_we_m_o=1 addr 4 data 0xBEEF; rf_we_e_o=0; fwd_dste_o=F, fwd_dstm_o=4.
- Load mrmovq with stat=10 (ADR) -> no write enables, stat_o=10; halted_o=1 next edge; further m_* (valid, AOK) ignored; retired_o unchanged for 5 cycles.
- Hold w_stall_i=1 for 3 cycles on an OPq (dstE=1) -> rf_we_e_o stays 1 and outputs stay constant; retired_o increases by exactly 1 after release.
- w_bubble_i=1 and w_stall_i=1 together -> next cycle valid=0, stat_o=00, fwd_* = F, no writes.
- With CNT_W=3, retire 10 AOK instructions -> retired_o saturates at 7. Then assert rst_i while halted -> outputs return to reset values next cycle.
